// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: mnemonic codes, MIPS opcode/funct constants, loader states
// and word-packing helpers shared by the loader, its encoder and the bench.
package instr_enc_pkg;

  // Mnemonic codes presented on In_Op; codes above OP_MUL are unknown.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SRL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_LW   = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_SB   = 5'd8;
  localparam logic [4:0] OP_LH   = 5'd9;
  localparam logic [4:0] OP_LB   = 5'd10;
  localparam logic [4:0] OP_ANDI = 5'd11;
  localparam logic [4:0] OP_ORI  = 5'd12;
  localparam logic [4:0] OP_XORI = 5'd13;
  localparam logic [4:0] OP_SLTI = 5'd14;
  localparam logic [4:0] OP_BEQ  = 5'd15;
  localparam logic [4:0] OP_BNE  = 5'd16;
  localparam logic [4:0] OP_BGTZ = 5'd17;
  localparam logic [4:0] OP_BLEZ = 5'd18;
  localparam logic [4:0] OP_BGEZ = 5'd19;
  localparam logic [4:0] OP_BLTZ = 5'd20;
  localparam logic [4:0] OP_J    = 5'd21;
  localparam logic [4:0] OP_JAL  = 5'd22;
  localparam logic [4:0] OP_MUL  = 5'd23;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_REGIMM = 6'h01;
  localparam logic [5:0] OPC_J      = 6'h02;
  localparam logic [5:0] OPC_JAL    = 6'h03;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  localparam logic [5:0] OPC_BNE    = 6'h05;
  localparam logic [5:0] OPC_BLEZ   = 6'h06;
  localparam logic [5:0] OPC_BGTZ   = 6'h07;
  localparam logic [5:0] OPC_ADDI   = 6'h08;
  localparam logic [5:0] OPC_SLTI   = 6'h0A;
  localparam logic [5:0] OPC_ANDI   = 6'h0C;
  localparam logic [5:0] OPC_ORI    = 6'h0D;
  localparam logic [5:0] OPC_XORI   = 6'h0E;
  localparam logic [5:0] OPC_SPEC2  = 6'h1C;
  localparam logic [5:0] OPC_LB     = 6'h20;
  localparam logic [5:0] OPC_LH     = 6'h21;
  localparam logic [5:0] OPC_LW     = 6'h23;
  localparam logic [5:0] OPC_SB     = 6'h28;
  localparam logic [5:0] OPC_SW     = 6'h2B;

  // Function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_MUL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [31:0] pack_r(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt, input logic [5:0] funct);
    return {opc, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Host-side instruction stream plus instruction-memory write port of the loader.
interface instr_encode_loader_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  In_Op;
  logic [4:0]  In_Rs;
  logic [4:0]  In_Rt;
  logic [4:0]  In_Rd;
  logic [4:0]  In_Shamt;
  logic [15:0] In_Imm;
  logic [25:0] In_Target;
  logic        Mem_WrEn;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Data;

  // Host / boot side: supplies instructions, observes the memory writes.
  modport master (
    output In_Valid, In_Op, In_Rs, In_Rt, In_Rd, In_Shamt, In_Imm, In_Target,
    input  In_Ready, Mem_WrEn, Mem_Addr, Mem_Data
  );

  // Loader side.
  modport slave (
    input  In_Valid, In_Op, In_Rs, In_Rt, In_Rd, In_Shamt, In_Imm, In_Target,
    output In_Ready, Mem_WrEn, Mem_Addr, Mem_Data
  );
endinterface

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: combinational symbolic fields -> 32-bit MIPS word.
// With ENC_ERR_CHECK_EN an illegal flag is also produced (unknown mnemonic,
// or a shift carrying a nonzero rs).
module instr_word_encoder
  import instr_enc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o
`ifdef ENC_ERR_CHECK_EN
  ,
  output logic        illegal_o
`endif
);

  // Mnemonic table; unknown codes produce an all-zero word (NOP).
  always_comb begin
    word_o = '0;
    case (op_i)
      OP_ADD:  word_o = pack_r(OPC_RTYPE, rs_i, rt_i, rd_i, shamt_i, FN_ADD);
      OP_SUB:  word_o = pack_r(OPC_RTYPE, rs_i, rt_i, rd_i, shamt_i, FN_SUB);
      OP_SLL:  word_o = pack_r(OPC_RTYPE, rs_i, rt_i, rd_i, shamt_i, FN_SLL);
      OP_SRL:  word_o = pack_r(OPC_RTYPE, rs_i, rt_i, rd_i, shamt_i, FN_SRL);
      OP_JR:   word_o = pack_r(OPC_RTYPE, rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_MUL:  word_o = pack_r(OPC_SPEC2, rs_i, rt_i, rd_i, 5'd0, FN_MUL);
      OP_ADDI: word_o = pack_i(OPC_ADDI, rs_i, rt_i, imm_i);
      OP_LW:   word_o = pack_i(OPC_LW,   rs_i, rt_i, imm_i);
      OP_SW:   word_o = pack_i(OPC_SW,   rs_i, rt_i, imm_i);
      OP_SB:   word_o = pack_i(OPC_SB,   rs_i, rt_i, imm_i);
      OP_LH:   word_o = pack_i(OPC_LH,   rs_i, rt_i, imm_i);
      OP_LB:   word_o = pack_i(OPC_LB,   rs_i, rt_i, imm_i);
      OP_ANDI: word_o = pack_i(OPC_ANDI, rs_i, rt_i, imm_i);
      OP_ORI:  word_o = pack_i(OPC_ORI,  rs_i, rt_i, imm_i);
      OP_XORI: word_o = pack_i(OPC_XORI, rs_i, rt_i, imm_i);
      OP_SLTI: word_o = pack_i(OPC_SLTI, rs_i, rt_i, imm_i);
      OP_BEQ:  word_o = pack_i(OPC_BEQ,  rs_i, rt_i, imm_i);
      OP_BNE:  word_o = pack_i(OPC_BNE,  rs_i, rt_i, imm_i);
      // Single-register branches: rt is part of the opcode space, not an operand.
      OP_BGTZ: word_o = pack_i(OPC_BGTZ,   rs_i, 5'd0, imm_i);
      OP_BLEZ: word_o = pack_i(OPC_BLEZ,   rs_i, 5'd0, imm_i);
      OP_BGEZ: word_o = pack_i(OPC_REGIMM, rs_i, 5'd1, imm_i);
      OP_BLTZ: word_o = pack_i(OPC_REGIMM, rs_i, 5'd0, imm_i);
      OP_J:    word_o = {OPC_J, target_i};
      OP_JAL:  word_o = {OPC_JAL, target_i};
      default: word_o = '0;
    endcase
  end

`ifdef ENC_ERR_CHECK_EN
  assign illegal_o = (op_i > OP_MUL) ||
                     (((op_i == OP_SLL) || (op_i == OP_SRL)) && (rs_i != 5'd0));
`endif

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: accepts symbolic instructions over a valid/ready
// handshake and writes the encoded words sequentially into instruction memory
// starting at BASE_ADDR, at most DEPTH per session (DEPTH <= 127).
// Optional feature macro ENC_ERR_CHECK_EN: rejects illegal instructions and
// raises a sticky Err output instead of writing them.
module instr_encode_loader
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic                  Finish,
  instr_encode_loader_if.slave  bus,
  output logic [6:0]            Count,
  output logic                  Busy,
  output logic                  Done
`ifdef ENC_ERR_CHECK_EN
  ,
  output logic                  Err
`endif
);

  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [6:0]  count_q, count_d;
  logic [31:0] enc_word;
  logic        enc_ok;
  logic        accept;

`ifdef ENC_ERR_CHECK_EN
  logic err_q, err_d;
  logic enc_illegal;
`endif

  instr_word_encoder u_enc (
    .op_i      (bus.In_Op),
    .rs_i      (bus.In_Rs),
    .rt_i      (bus.In_Rt),
    .rd_i      (bus.In_Rd),
    .shamt_i   (bus.In_Shamt),
    .imm_i     (bus.In_Imm),
    .target_i  (bus.In_Target),
    .word_o    (enc_word)
`ifdef ENC_ERR_CHECK_EN
    ,
    .illegal_o (enc_illegal)
`endif
  );

`ifdef ENC_ERR_CHECK_EN
  assign enc_ok = !enc_illegal;
`else
  assign enc_ok = 1'b1;
`endif

  // Finish has priority over a simultaneous instruction.
  assign accept = (state_q == ST_LOAD) && !Finish && bus.In_Valid;

  // FSM next-state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    bus.In_Ready = 1'b0;
    bus.Mem_WrEn = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bus.In_Ready = 1'b1;
        Busy         = 1'b1;
        if (Finish)                state_d = ST_DONE;
        else if (accept && enc_ok) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bus.Mem_WrEn = 1'b1;
        Busy         = 1'b1;
        state_d      = ((count_q + 7'd1) < DEPTH_C) ? ST_LOAD : ST_DONE;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: session restart, word capture, post-write advance.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
`ifdef ENC_ERR_CHECK_EN
    err_d   = err_q;
`endif
    if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && Start) begin
      addr_d  = BASE_ADDR;
      count_d = '0;
`ifdef ENC_ERR_CHECK_EN
      err_d   = 1'b0;
`endif
    end
    if (accept && enc_ok) data_d = enc_word;
`ifdef ENC_ERR_CHECK_EN
    if (accept && !enc_ok) err_d = 1'b1;
`endif
    if (state_q == ST_WRITE) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + 7'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      count_q <= '0;
`ifdef ENC_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
`ifdef ENC_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.Mem_Addr = addr_q;
  assign bus.Mem_Data = data_q;
  assign Count        = count_q;
`ifdef ENC_ERR_CHECK_EN
  assign Err          = err_q;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader (DEPTH=4, BASE_ADDR=0x100).
// A session-level reference model tracks the expected outputs each cycle;
// directed literal checks pin the encoder table and boundary behaviour.
module tb_instr_encode_loader;
  import instr_enc_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       finish = 1'b0;
  logic [6:0] count;
  logic       busy, done;
`ifdef ENC_ERR_CHECK_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  instr_encode_loader_if bus ();

  instr_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .Clk    (clk),
    .Rst_n  (rst_n),
    .Start  (start),
    .Finish (finish),
    .bus    (bus),
    .Count  (count),
    .Busy   (busy),
    .Done   (done)
`ifdef ENC_ERR_CHECK_EN
    ,
    .Err    (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input logic [4:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] tgt);
    case (op)
      OP_ADD:  return {6'h00, rs, rt, rd, sh, 6'h20};
      OP_SUB:  return {6'h00, rs, rt, rd, sh, 6'h22};
      OP_SLL:  return {6'h00, rs, rt, rd, sh, 6'h00};
      OP_SRL:  return {6'h00, rs, rt, rd, sh, 6'h02};
      OP_JR:   return {6'h00, rs, 15'd0, 6'h08};
      OP_MUL:  return {6'h1C, rs, rt, rd, 5'd0, 6'h02};
      OP_ADDI: return {6'h08, rs, rt, imm};
      OP_LW:   return {6'h23, rs, rt, imm};
      OP_SW:   return {6'h2B, rs, rt, imm};
      OP_SB:   return {6'h28, rs, rt, imm};
      OP_LH:   return {6'h21, rs, rt, imm};
      OP_LB:   return {6'h20, rs, rt, imm};
      OP_ANDI: return {6'h0C, rs, rt, imm};
      OP_ORI:  return {6'h0D, rs, rt, imm};
      OP_XORI: return {6'h0E, rs, rt, imm};
      OP_SLTI: return {6'h0A, rs, rt, imm};
      OP_BEQ:  return {6'h04, rs, rt, imm};
      OP_BNE:  return {6'h05, rs, rt, imm};
      OP_BGTZ: return {6'h07, rs, 5'd0, imm};
      OP_BLEZ: return {6'h06, rs, 5'd0, imm};
      OP_BGEZ: return {6'h01, rs, 5'd1, imm};
      OP_BLTZ: return {6'h01, rs, 5'd0, imm};
      OP_J:    return {6'h02, tgt};
      OP_JAL:  return {6'h03, tgt};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [4:0] op, input logic [4:0] rs);
`ifdef ENC_ERR_CHECK_EN
    return !((int'(op) > 23) || (((op == OP_SLL) || (op == OP_SRL)) && (rs != 5'd0)));
`else
    return (op == op) && (rs == rs);
`endif
  endfunction

  // Session model: m_active = session open, m_wr = a write is due this cycle.
  bit          m_active = 0, m_done = 0, m_wr = 0, m_err = 0;
  int          m_count = 0;
  logic [31:0] m_addr = BASE, m_data = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_done <= 0; m_wr <= 0; m_err <= 0;
      m_count <= 0; m_addr <= BASE; m_data <= 32'h0;
    end else if (m_wr) begin
      m_wr    <= 0;
      m_addr  <= m_addr + 32'd4;
      m_count <= m_count + 1;
      if (m_count + 1 == DEPTH) begin
        m_active <= 0;
        m_done   <= 1;
      end
    end else if (m_active) begin
      if (finish) begin
        m_active <= 0;
        m_done   <= 1;
      end else if (bus.In_Valid) begin
        if (ref_legal(bus.In_Op, bus.In_Rs)) begin
          m_wr   <= 1;
          m_data <= ref_word(bus.In_Op, bus.In_Rs, bus.In_Rt, bus.In_Rd,
                             bus.In_Shamt, bus.In_Imm, bus.In_Target);
        end else begin
          m_err <= 1;
        end
      end
    end else if (start) begin
      m_active <= 1; m_done <= 0; m_err <= 0;
      m_count  <= 0; m_addr <= BASE;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_ready", {31'd0, bus.In_Ready}, {31'd0, m_active && !m_wr});
    chk("model_wren",  {31'd0, bus.Mem_WrEn}, {31'd0, m_wr});
    chk("model_addr",  bus.Mem_Addr, m_addr);
    chk("model_data",  bus.Mem_Data, m_data);
    chk("model_count", {25'd0, count}, 32'(m_count));
    chk("model_busy",  {31'd0, busy}, {31'd0, m_active});
    chk("model_done",  {31'd0, done}, {31'd0, m_done});
`ifdef ENC_ERR_CHECK_EN
    chk("model_err",   {31'd0, err}, {31'd0, m_err});
`endif
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    bus.In_Op = op; bus.In_Rs = rs; bus.In_Rt = rt; bus.In_Rd = rd;
    bus.In_Shamt = sh; bus.In_Imm = imm; bus.In_Target = tgt;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.In_Ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: In_Ready stayed 0 expected 1", name);
    end
  endtask

  task automatic send(input string name, input logic [4:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] exp_word,
                      input logic [31:0] exp_addr);
    wait_ready(name);
    drive(op, rs, rt, rd, 5'd0, imm, tgt);
    bus.In_Valid = 1'b1;
    @(negedge clk);
    bus.In_Valid = 1'b0;
    chk({name, "_wren"}, {31'd0, bus.Mem_WrEn}, 32'd1);
    chk({name, "_data"}, bus.Mem_Data, exp_word);
    chk({name, "_addr"}, bus.Mem_Addr, exp_addr);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int writes;
    bus.In_Valid = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);

    repeat (3) @(negedge clk);
    chk("reset_addr",  bus.Mem_Addr, BASE);
    chk("reset_ready", {31'd0, bus.In_Ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Session 1: fill to DEPTH with literal encodings.
    pulse_start();
    send("addi", OP_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 32'h2008_0005, BASE);
    send("lw",   OP_LW,   5'd8, 5'd9, 5'd0, 16'd4, 26'd0, 32'h8D09_0004, BASE + 32'h4);
    send("add",  OP_ADD,  5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h0022_1820, BASE + 32'h8);
    send("j",    OP_J,    5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 32'h0800_0010, BASE + 32'hC);
    @(negedge clk);
    chk("s1_done",  {31'd0, done}, 32'd1);
    chk("s1_count", {25'd0, count}, 32'd4);

    // Session 2: REGIMM branches ignore the supplied rt, then early Finish.
    pulse_start();
    send("bgez", OP_BGEZ, 5'd4, 5'd7, 5'd0, 16'd3, 26'd0, 32'h0481_0003, BASE);
    send("bltz", OP_BLTZ, 5'd4, 5'd5, 5'd0, 16'd3, 26'd0, 32'h0480_0003, BASE + 32'h4);
    wait_ready("fin");
    drive(OP_ADD, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    finish = 1'b1;
    bus.In_Valid = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    bus.In_Valid = 1'b0;
    chk("fin_wren",  {31'd0, bus.Mem_WrEn}, 32'd0);
    chk("fin_done",  {31'd0, done}, 32'd1);
    chk("fin_count", {25'd0, count}, 32'd2);
    pulse_start();
    chk("restart_addr",  bus.Mem_Addr, BASE);
    chk("restart_count", {25'd0, count}, 32'd0);

    // Session 3: In_Valid held; exactly DEPTH writes, then full.
    drive(OP_ORI, 5'd3, 5'd6, 5'd0, 5'd0, 16'hBEEF, 26'd0);
    bus.In_Valid = 1'b1;
    writes = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.Mem_WrEn) begin
        chk("full_addr", bus.Mem_Addr, BASE + 32'(4 * writes));
        chk("full_data", bus.Mem_Data, 32'h3466_BEEF);
        writes++;
      end
    end
    bus.In_Valid = 1'b0;
    chk("full_writes", 32'(writes), 32'd4);
    chk("full_done",   {31'd0, done}, 32'd1);
    chk("full_ready",  {31'd0, bus.In_Ready}, 32'd0);
    chk("full_count",  {25'd0, count}, 32'd4);
    chk("full_addr_end", bus.Mem_Addr, BASE + 32'h10);

    // Reset asserted during a WRITE cycle.
    pulse_start();
    send("pre_rst", OP_SUB, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h0022_1822, BASE);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wren",  {31'd0, bus.Mem_WrEn}, 32'd0);
    chk("rst_addr",  bus.Mem_Addr, BASE);
    chk("rst_data",  bus.Mem_Data, 32'd0);
    chk("rst_count", {25'd0, count}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unknown mnemonic.
    pulse_start();
    wait_ready("unk");
    drive(5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h3FF);
    bus.In_Valid = 1'b1;
    @(negedge clk);
    bus.In_Valid = 1'b0;
`ifdef ENC_ERR_CHECK_EN
    chk("unk_wren",  {31'd0, bus.Mem_WrEn}, 32'd0);
    chk("unk_err",   {31'd0, err}, 32'd1);
    @(negedge clk);
    chk("unk_count", {25'd0, count}, 32'd0);
`else
    chk("unk_wren",  {31'd0, bus.Mem_WrEn}, 32'd1);
    chk("unk_data",  bus.Mem_Data, 32'd0);
    @(negedge clk);
    chk("unk_count", {25'd0, count}, 32'd1);
`endif

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      start  = m_active ? ($urandom_range(15) == 0) : ($urandom_range(3) == 0);
      finish = ($urandom_range(19) == 0);
      bus.In_Valid = $urandom_range(1) == 1;
      drive(($urandom_range(7) == 0) ? 5'($urandom_range(31, 24)) : 5'($urandom_range(23)),
            ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      @(negedge clk);
    end
    start = 1'b0;
    finish = 1'b0;
    bus.In_Valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
